// File: rtl/odo_pkg.sv
// ---------------------------------------------------------------------------
// odo_pkg
// Shared constants and types for the FX3 work receiver.
//   HDR_WORDS / TGT_WORDS : default 32-bit word counts of header and target
//   BLK_WORDS             : words captured per burst (header + target)
//   CNT_W                 : width of the burst word counter
//   odo_state_e           : receiver FSM state encoding
// ---------------------------------------------------------------------------
package odo_pkg;

    localparam int HDR_WORDS = 19;
    localparam int TGT_WORDS = 8;
    localparam int BLK_WORDS = HDR_WORDS + TGT_WORDS;
    localparam int CNT_W     = 5;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEAD   = 3'd1,
        RECV   = 3'd2,
        DRAIN  = 3'd3,
        COMMIT = 3'd4
    } odo_state_e;

endpackage

// File: rtl/odo_work_rx.sv
// ---------------------------------------------------------------------------
// odo_work_rx
// Receives one block of mining work per FX3 strobe burst, buffers it in a
// shadow register and hands it to the hash core as a single pending item.
//
// Ports
//   pclk         in   single clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   dq_in        in   32-bit FX3 data bus
//   strobe_data  in   FX3 burst strobe, active high
//   rx_ready_n   out  low only while the receiver is idle
//   header       out  delivered block header, word i at [32*i +: 32]
//   target       out  delivered target, first target word in the top 32 bits
//   job_id       out  sequence number of the delivered work (wraps)
//   work_valid   out  delivered work pending for the hash core
//   work_ready   in   hash core accepts pending work
//   err_short    out  one-cycle pulse: burst ended before all words arrived
//   err_long     out  one-cycle pulse: burst carried extra words
//   overrun      out  one-cycle pulse: pending work replaced before taken
//   dbg_state    out  current FSM state
//
// Handshake: work is transferred on every cycle where work_valid and
// work_ready are both high; work_valid then drops on the next cycle unless a
// new block commits in that same cycle, in which case it stays high and the
// outputs carry the new block.
//
// Burst framing: the first strobe cycle (seen while idle) is a lead-in and
// its data is dropped; each following strobe cycle carries one word, starting
// with word 0 in the LEAD cycle. The strobe falling after the last word
// commits the block; work_valid rises two cycles after that fall.
// ---------------------------------------------------------------------------
module odo_work_rx #(
    parameter int HDR_WORDS = odo_pkg::HDR_WORDS,
    parameter int TGT_WORDS = odo_pkg::TGT_WORDS
) (
    input  logic                      pclk,
    input  logic                      rst_n,
    input  logic [31:0]               dq_in,
    input  logic                      strobe_data,
    output logic                      rx_ready_n,
    output logic [32*HDR_WORDS-1:0]   header,
    output logic [32*TGT_WORDS-1:0]   target,
    output logic [7:0]                job_id,
    output logic                      work_valid,
    input  logic                      work_ready,
    output logic                      err_short,
    output logic                      err_long,
    output logic                      overrun,
    output odo_pkg::odo_state_e       dbg_state
);
    import odo_pkg::*;

    localparam int HDR_W = 32 * HDR_WORDS;
    localparam int TGT_W = 32 * TGT_WORDS;
    localparam int BLK   = HDR_WORDS + TGT_WORDS;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BLK);

    odo_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               armed_q, armed_d;
    logic [31:0]        shadow_q [BLK];
    logic [31:0]        shadow_d [BLK];
    logic [HDR_W-1:0]   header_q, header_d;
    logic [TGT_W-1:0]   target_q, target_d;
    logic [7:0]         job_id_q, job_id_d;
    logic               work_valid_q, work_valid_d;
    logic               err_short_q, err_short_d;
    logic               err_long_q, err_long_d;
    logic               overrun_q, overrun_d;
    logic               rx_ready_n_q, rx_ready_n_d;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        // A burst already running when reset releases must not be taken as
        // a new block: the receiver only arms after seeing the strobe low.
        armed_d      = armed_q | ~strobe_data;
        shadow_d     = shadow_q;
        header_d     = header_q;
        target_d     = target_q;
        job_id_d     = job_id_q;
        work_valid_d = work_valid_q & ~work_ready;
        err_short_d  = 1'b0;
        err_long_d   = 1'b0;
        overrun_d    = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (strobe_data && armed_q) begin
                    state_d = LEAD;
                end
            end

            LEAD: begin
                if (strobe_data) begin
                    shadow_d[0] = dq_in;
                    cnt_d       = CNT_W'(1);
                    state_d     = RECV;
                end else begin
                    err_short_d = 1'b1;
                    state_d     = IDLE;
                end
            end

            RECV: begin
                // cnt_q == CNT_FULL means every word is in; this cycle's
                // strobe decides between a clean end and an over-long burst.
                if (cnt_q == CNT_FULL) begin
                    if (strobe_data) begin
                        err_long_d = 1'b1;
                        state_d    = DRAIN;
                    end else begin
                        state_d    = COMMIT;
                    end
                end else if (strobe_data) begin
                    shadow_d[cnt_q] = dq_in;
                    cnt_d           = cnt_q + 1'b1;
                end else begin
                    err_short_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = IDLE;
                end
            end

            DRAIN: begin
                if (!strobe_data) begin
                    state_d = COMMIT;
                end
            end

            COMMIT: begin
                for (int i = 0; i < HDR_WORDS; i++) begin
                    header_d[32*i +: 32] = shadow_q[i];
                end
                for (int k = 0; k < TGT_WORDS; k++) begin
                    target_d[TGT_W-32-32*k +: 32] = shadow_q[HDR_WORDS+k];
                end
                job_id_d     = job_id_q + 8'd1;
                work_valid_d = 1'b1;
                // Latest block wins; flag only if the old one was never taken.
                overrun_d    = work_valid_q & ~work_ready;
                cnt_d        = '0;
                // A strobe here is the lead-in of the next burst.
                state_d      = strobe_data ? LEAD : IDLE;
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        rx_ready_n_d = (state_d != IDLE);
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            armed_q      <= 1'b0;
            for (int i = 0; i < BLK; i++) begin
                shadow_q[i] <= '0;
            end
            header_q     <= '0;
            target_q     <= '0;
            job_id_q     <= '0;
            work_valid_q <= 1'b0;
            err_short_q  <= 1'b0;
            err_long_q   <= 1'b0;
            overrun_q    <= 1'b0;
            rx_ready_n_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            armed_q      <= armed_d;
            shadow_q     <= shadow_d;
            header_q     <= header_d;
            target_q     <= target_d;
            job_id_q     <= job_id_d;
            work_valid_q <= work_valid_d;
            err_short_q  <= err_short_d;
            err_long_q   <= err_long_d;
            overrun_q    <= overrun_d;
            rx_ready_n_q <= rx_ready_n_d;
        end
    end

    assign rx_ready_n = rx_ready_n_q;
    assign header     = header_q;
    assign target     = target_q;
    assign job_id     = job_id_q;
    assign work_valid = work_valid_q;
    assign err_short  = err_short_q;
    assign err_long   = err_long_q;
    assign overrun    = overrun_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_odo_work_rx.sv
// ---------------------------------------------------------------------------
// tb_odo_work_rx
// Directed bench for odo_work_rx. A burst-level model tracks what the
// delivered work must be (commit two cycles after the strobe falls, consume
// on valid&ready, latest block wins) and is compared against the DUT every
// cycle; hand-computed literals pin the model at key points.
// ---------------------------------------------------------------------------
module tb_odo_work_rx;
    import odo_pkg::*;

    localparam int HW = 32 * 19;
    localparam int TW = 32 * 8;
    localparam int BW = 27;

    // ---------------- clock / reset ----------------
    logic             pclk = 1'b0;
    logic             rst_n;
    logic [31:0]      dq_in;
    logic             strobe_data;
    logic             work_ready;
    logic             rx_ready_n;
    logic [HW-1:0]    header;
    logic [TW-1:0]    target;
    logic [7:0]       job_id;
    logic             work_valid;
    logic             err_short;
    logic             err_long;
    logic             overrun;
    odo_state_e       dbg_state;

    always #5 pclk = ~pclk;

    int cyc = 0;
    always @(posedge pclk) cyc <= cyc + 1;

    odo_work_rx dut (
        .pclk        (pclk),
        .rst_n       (rst_n),
        .dq_in       (dq_in),
        .strobe_data (strobe_data),
        .rx_ready_n  (rx_ready_n),
        .header      (header),
        .target      (target),
        .job_id      (job_id),
        .work_valid  (work_valid),
        .work_ready  (work_ready),
        .err_short   (err_short),
        .err_long    (err_long),
        .overrun     (overrun),
        .dbg_state   (dbg_state)
    );

    // ---------------- check bookkeeping ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [HW-1:0] act,
                       input logic [HW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // ---------------- scoreboard / model ----------------
    logic [31:0]   tb_words [BW];
    int            exp_cyc_q [$];
    logic [HW-1:0] exp_hdr_q [$];
    logic [TW-1:0] exp_tgt_q [$];

    logic          m_valid = 1'b0;
    logic [7:0]    m_job   = '0;
    logic [HW-1:0] m_hdr   = '0;
    logic [TW-1:0] m_tgt   = '0;
    logic          m_ovr   = 1'b0;
    logic          wr_prev = 1'b0;

    int n_short = 0;
    int n_long  = 0;
    int n_ovr   = 0;

    function automatic logic [HW-1:0] mk_hdr();
        logic [HW-1:0] h = '0;
        for (int i = 0; i < 19; i++) h[32*i +: 32] = tb_words[i];
        return h;
    endfunction

    // Target word k sits at target[255-32k : 224-32k].
    function automatic logic [TW-1:0] mk_tgt();
        logic [TW-1:0] t = '0;
        for (int k = 0; k < 8; k++) t[TW-32-32*k +: 32] = tb_words[19+k];
        return t;
    endfunction

    always @(negedge pclk) begin
        if (!rst_n) begin
            m_valid = 1'b0;
            m_job   = '0;
            m_hdr   = '0;
            m_tgt   = '0;
            m_ovr   = 1'b0;
            exp_cyc_q.delete();
            exp_hdr_q.delete();
            exp_tgt_q.delete();
        end else begin
            m_ovr = 1'b0;
            if (exp_cyc_q.size() > 0 && exp_cyc_q[0] == cyc) begin
                m_ovr   = m_valid && !wr_prev;
                m_valid = 1'b1;
                m_job   = m_job + 8'd1;
                m_hdr   = exp_hdr_q.pop_front();
                m_tgt   = exp_tgt_q.pop_front();
                void'(exp_cyc_q.pop_front());
            end else if (m_valid && wr_prev) begin
                m_valid = 1'b0;
            end
            n_short += int'(err_short);
            n_long  += int'(err_long);
            n_ovr   += int'(overrun);
        end
        chk("cyc_work_valid", HW'(work_valid), HW'(m_valid));
        chk("cyc_job_id", HW'(job_id), HW'(m_job));
        chk("cyc_header", header, m_hdr);
        chk("cyc_target", HW'(target), HW'(m_tgt));
        chk("cyc_overrun", HW'(overrun), HW'(m_ovr));
        wr_prev = work_ready;
    end

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge pclk); #1;
            strobe_data = 1'b0;
            dq_in       = $urandom;
        end
    endtask

    task automatic fill_pat(input logic [31:0] base);
        for (int i = 0; i < BW; i++) tb_words[i] = base + 32'h101 * i;
    endtask

    // Strobe high for n_strobe cycles: one lead-in, then words, then junk.
    // Returns with the strobe low in the fall cycle.
    task automatic send_burst(input int n_strobe, output int fall_cyc);
        for (int i = 0; i < n_strobe; i++) begin
            @(posedge pclk); #1;
            strobe_data = 1'b1;
            if (i >= 1 && i <= BW) dq_in = tb_words[i-1];
            else dq_in = $urandom;
        end
        @(posedge pclk); #1;
        strobe_data = 1'b0;
        dq_in       = $urandom;
        fall_cyc    = cyc;
        if (n_strobe >= BW + 1) begin
            exp_cyc_q.push_back(cyc + 2);
            exp_hdr_q.push_back(mk_hdr());
            exp_tgt_q.push_back(mk_tgt());
        end
    endtask

    task automatic consume();
        @(posedge pclk); #1 work_ready = 1'b1;
        @(posedge pclk); #1 work_ready = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int f;
        int s0;
        int l0;
        int o0;
        rst_n       = 1'b0;
        strobe_data = 1'b0;
        dq_in       = '0;
        work_ready  = 1'b0;

        // Reset values
        repeat (3) @(posedge pclk);
        @(negedge pclk);
        chk("rst_rx_ready_n", HW'(rx_ready_n), HW'(1'b1));
        chk("rst_err_short", HW'(err_short), HW'(1'b0));
        chk("rst_err_long", HW'(err_long), HW'(1'b0));
        @(posedge pclk); #1 rst_n = 1'b1;
        @(negedge pclk);
        chk("rel_rx_ready_n_first", HW'(rx_ready_n), HW'(1'b1));
        @(negedge pclk);
        chk("rel_rx_ready_n_next", HW'(rx_ready_n), HW'(1'b0));
        idle(2);

        // Reference block, 28-cycle strobe
        for (int i = 0; i < BW; i++) tb_words[i] = 32'h11110000 + i;
        tb_words[0]  = 32'h20000e02;
        tb_words[18] = 32'h1c5c279b;
        tb_words[19] = 32'h00000021;
        tb_words[20] = 32'h55340000;
        for (int i = 21; i < BW; i++) tb_words[i] = 32'h0;
        send_burst(28, f);
        @(negedge pclk);
        @(negedge pclk);
        chk("a_valid_fall_plus1", HW'(work_valid), HW'(1'b0));
        chk("a_rx_ready_n_busy", HW'(rx_ready_n), HW'(1'b1));
        @(negedge pclk);
        chk("a_valid_fall_plus2", HW'(work_valid), HW'(1'b1));
        chk("a_hdr_w0", HW'(header[31:0]), HW'(32'h20000e02));
        chk("a_hdr_w18", HW'(header[607:576]), HW'(32'h1c5c279b));
        chk("a_tgt_w0", HW'(target[255:224]), HW'(32'h00000021));
        chk("a_tgt_w1", HW'(target[223:192]), HW'(32'h55340000));
        chk("a_tgt_low", HW'(target[191:0]), HW'(192'h0));
        chk("a_job_id", HW'(job_id), HW'(8'd1));
        consume();
        idle(2);
        @(negedge pclk);
        chk("a_consumed", HW'(work_valid), HW'(1'b0));

        // Short burst (10 strobe cycles) and lead-only burst
        s0 = n_short;
        fill_pat(32'h77000000);
        send_burst(10, f);
        idle(4);
        @(negedge pclk);
        chk("b_err_short_cnt", HW'(n_short - s0), HW'(1));
        chk("b_valid", HW'(work_valid), HW'(1'b0));
        chk("b_job_id", HW'(job_id), HW'(8'd1));
        chk("b_rx_ready_n", HW'(rx_ready_n), HW'(1'b0));
        send_burst(1, f);
        idle(4);
        @(negedge pclk);
        chk("b_lead_only_short", HW'(n_short - s0), HW'(2));

        // Long burst (31 strobe cycles)
        l0 = n_long;
        fill_pat(32'hA5000000);
        send_burst(31, f);
        idle(4);
        @(negedge pclk);
        chk("c_err_long_cnt", HW'(n_long - l0), HW'(1));
        chk("c_job_id", HW'(job_id), HW'(8'd2));
        chk("c_valid", HW'(work_valid), HW'(1'b1));
        chk("c_hdr_w0", HW'(header[31:0]), HW'(32'hA5000000));
        chk("c_tgt_w0", HW'(target[255:224]), HW'(32'hA5001313));
        chk("c_tgt_w7", HW'(target[31:0]), HW'(32'hA5001A1A));
        consume();
        idle(2);

        // Two bursts, nothing taken: overrun on the second
        o0 = n_ovr;
        fill_pat(32'h3C000000);
        send_burst(28, f);
        idle(3);
        fill_pat(32'h4D000000);
        send_burst(28, f);
        idle(4);
        @(negedge pclk);
        chk("d_overrun_cnt", HW'(n_ovr - o0), HW'(1));
        chk("d_job_id", HW'(job_id), HW'(8'd4));
        chk("d_hdr_w0", HW'(header[31:0]), HW'(32'h4D000000));

        // Commit in the same cycle the pending work is taken
        o0 = n_ovr;
        fill_pat(32'h5E000000);
        send_burst(28, f);
        @(posedge pclk); #1 work_ready = 1'b1;
        @(posedge pclk); #1 work_ready = 1'b0;
        @(negedge pclk);
        chk("e_valid_kept", HW'(work_valid), HW'(1'b1));
        chk("e_job_id", HW'(job_id), HW'(8'd5));
        idle(3);
        @(negedge pclk);
        chk("e_no_overrun", HW'(n_ovr - o0), HW'(0));
        chk("e_hdr_w0", HW'(header[31:0]), HW'(32'h5E000000));
        consume();
        idle(2);

        // Back-to-back: next lead-in lands in the commit cycle
        o0 = n_ovr;
        s0 = n_short;
        fill_pat(32'h6F000000);
        send_burst(28, f);
        fill_pat(32'h70000000);
        send_burst(28, f);
        idle(4);
        @(negedge pclk);
        chk("f_job_id", HW'(job_id), HW'(8'd7));
        chk("f_hdr_w0", HW'(header[31:0]), HW'(32'h70000000));
        chk("f_overrun_cnt", HW'(n_ovr - o0), HW'(1));
        chk("f_no_short", HW'(n_short - s0), HW'(0));
        consume();
        idle(2);

        // Reset at word 12, burst still running through release
        fill_pat(32'h81000000);
        for (int i = 0; i <= 13; i++) begin
            @(posedge pclk); #1;
            strobe_data = 1'b1;
            dq_in = (i == 0) ? $urandom : tb_words[i-1];
            if (i == 13) rst_n = 1'b0;
        end
        @(negedge pclk);
        chk("g_rst_header", header, '0);
        chk("g_rst_target", HW'(target), '0);
        chk("g_rst_job_id", HW'(job_id), HW'(8'd0));
        chk("g_rst_valid", HW'(work_valid), HW'(1'b0));
        chk("g_rst_rx_ready_n", HW'(rx_ready_n), HW'(1'b1));
        repeat (2) begin
            @(posedge pclk); #1 dq_in = $urandom;
        end
        @(posedge pclk); #1 rst_n = 1'b1;
        s0 = n_short;
        l0 = n_long;
        @(posedge pclk); #1 dq_in = $urandom;
        @(negedge pclk);
        chk("g_ignored_rx_ready_n", HW'(rx_ready_n), HW'(1'b0));
        @(posedge pclk); #1 dq_in = $urandom;
        idle(3);
        chk("g_no_short", HW'(n_short - s0), HW'(0));
        chk("g_no_long", HW'(n_long - l0), HW'(0));
        fill_pat(32'h92000000);
        send_burst(28, f);
        idle(4);
        @(negedge pclk);
        chk("g_job_id", HW'(job_id), HW'(8'd1));
        chk("g_valid", HW'(work_valid), HW'(1'b1));
        chk("g_hdr_w0", HW'(header[31:0]), HW'(32'h92000000));
        chk("g_tgt_w7", HW'(target[31:0]), HW'(32'h92001A1A));
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/odo_work_rx.md
ODO_WORK_RX -- requirements
Module: odo_work_rx

Interface
REQ-001 Parameter HDR_WORDS, default 19, number of 32-bit block-header words per burst.
REQ-002 Parameter TGT_WORDS, default 8, number of 32-bit target words per burst.
REQ-003 pclk  input  1  single clock, 100 MHz, all logic on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 dq_in  input  32  FX3 data bus, sampled while strobe_data high.
REQ-006 strobe_data  input  1  FX3 burst strobe, active high.
REQ-007 rx_ready_n  output  1  active-low "receiver idle, may send block" to FX3.
REQ-008 header  output  32*HDR_WORDS  delivered block header.
REQ-009 target  output  32*TGT_WORDS  delivered share target.
REQ-010 job_id  output  8  sequence number of delivered work.
REQ-011 work_valid  output  1  delivered work pending for hash core.
REQ-012 work_ready  input  1  hash core accepts pending work.
REQ-013 err_short, err_long, overrun  output  1 each  single-cycle error/status pulses.

Function
REQ-014 FSM states: IDLE, LEAD, RECV, DRAIN, COMMIT.
REQ-015 IDLE -> LEAD on first cycle strobe_data=1; that LEAD cycle is a lead-in and dq_in SHALL be ignored.
REQ-016 LEAD -> RECV next cycle if strobe_data=1, else -> IDLE with err_short pulse.
REQ-017 In RECV each strobe_data=1 cycle captures dq_in into shadow word[cnt], cnt 0..HDR_WORDS+TGT_WORDS-1 (5-bit counter).
REQ-018 Mapping: word i (i<HDR_WORDS) -> header[32*i+31:32*i]; word HDR_WORDS+k -> target[255-32*k:224-32*k].
REQ-019 strobe_data=0 in RECV before all 27 words captured -> IDLE, err_short pulse, shadow discarded, outputs untouched.
REQ-020 After word 26 captured: strobe_data=1 next cycle -> DRAIN; strobe_data=0 -> COMMIT.
REQ-021 DRAIN ignores dq_in, pulses err_long once on entry, -> COMMIT when strobe_data=0; burst still committed.
REQ-022 COMMIT (one cycle) copies shadow to header/target, increments job_id (wraps 255->0), sets work_valid=1, -> IDLE.
REQ-023 Commit while work_valid=1 and work_ready=0 SHALL overwrite pending work (latest wins) and pulse overrun.
REQ-024 work_valid clears the cycle after work_valid&&work_ready, unless a COMMIT occurs that same cycle, in which case it stays 1 with new data and no overrun.
REQ-025 header/target/job_id SHALL remain stable while work_valid=1 except at COMMIT.
REQ-026 rx_ready_n=0 only in IDLE; 1 in all other states.
REQ-027 Latency: work_valid rises 2 cycles after strobe_data falls following the final word.
REQ-028 Strobe asserted in COMMIT cycle starts a new burst: COMMIT -> LEAD directly.

Reset
REQ-029 rst_n=0 SHALL immediately force IDLE, cnt=0, header=0, target=0, job_id=0, work_valid=0, error pulses 0, rx_ready_n=1.
REQ-030 First cycle after reset release rx_ready_n=1; goes 0 from next cycle (IDLE registered).
REQ-031 Reset mid-burst discards shadow; bursts in progress at release are ignored until strobe_data seen low.

Structure
REQ-032 Package odo_pkg holds HDR_WORDS, TGT_WORDS, BLK_WORDS=27, FSM state enum.
REQ-033 Single module, no sub-modules; shadow register is 27x32 flops.

Verification
REQ-034 Reset, 28-cycle strobe, words 0x20000e02..0x1c5c279b, 0x00000021, 0x55340000, 0x0 x6 -> header[31:0]=0x20000e02, header[607:576]=0x1c5c279b, target[255:224]=0x00000021, target[223:192]=0x55340000, job_id=1, work_valid 2 cycles after strobe fall.
REQ-035 Strobe high 10 cycles only -> err_short pulse, work_valid stays 0, job_id unchanged, rx_ready_n back to 0.
REQ-036 Strobe high 31 cycles -> err_long single pulse, words 27+ ignored, commit with correct data.
REQ-037 Two full bursts, work_ready=0 -> overrun pulse at second commit, job_id=2, second block's data visible.
REQ-038 work_ready=1 in same cycle as COMMIT -> work_valid remains 1, no overrun, job_id advances.
REQ-039 rst_n=0 at word 12 then valid burst -> outputs 0 during reset, next burst delivered with job_id=1.
